// File: rtl/gray_seq_source_pkg.sv
// Shared definitions for the Gray-code sequence source and its converter peers.
package gray_seq_source_pkg;

  localparam int unsigned GRAY_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gray_state_t;

endpackage

// File: rtl/gray_seq_source_bin_to_gray.sv
// Combinational binary to reflected-Gray conversion.
module gray_seq_source_bin_to_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_seq_source.sv
// Emits a counted run of consecutive Gray codes over a valid/ready handshake.
module gray_seq_source
  import gray_seq_source_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_bin,
  input  logic [WIDTH:0]   count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] gray_out,
  output logic             gray_valid,
  input  logic             gray_ready,
  output logic             busy,
  output logic             done
);

  gray_state_t      r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH:0]   r_rem;
  logic             r_dir;
  logic [WIDTH-1:0] r_gray;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_bin_step;
  logic [WIDTH-1:0] w_conv_bin;
  logic [WIDTH-1:0] w_gray;
  logic             w_xfer;

  // Step wraps naturally modulo 2**WIDTH.
  assign w_bin_step = r_dir ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
  assign w_conv_bin = (r_state == ST_IDLE) ? start_bin : w_bin_step;
  assign w_xfer     = r_valid && gray_ready;

  gray_seq_source_bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .i_bin  (w_conv_bin),
    .o_gray (w_gray)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_gray  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_bin   <= start_bin;
              r_rem   <= count;
              r_dir   <= up_dn;
              r_gray  <= w_gray;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            if (r_rem == (WIDTH+1)'(1)) begin
              r_rem   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_rem  <= r_rem - (WIDTH+1)'(1);
              r_bin  <= w_bin_step;
              r_gray <= w_gray;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gray_out   = r_gray;
  assign gray_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_gray_seq_source.sv
// Directed self-checking bench for gray_seq_source at WIDTH=4.
`timescale 1ns/1ps
module tb_gray_seq_source;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] start_bin;
  logic [W:0]   count;
  logic         up_dn;
  logic [W-1:0] gray_out;
  logic         gray_valid;
  logic         gray_ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q_codes[$];
  int           ndone;
  int           done_cyc;
  int           last_xfer;
  logic         tr_v[64];
  logic         tr_r[64];
  logic [W-1:0] tr_g[64];

  always #5 clk = ~clk;

  gray_seq_source #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_bin  (start_bin),
    .count      (count),
    .up_dn      (up_dn),
    .gray_out   (gray_out),
    .gray_valid (gray_valid),
    .gray_ready (gray_ready),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  // Reference gray_to_bin used by the scoreboard.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Pulses start for one cycle; returns on the negedge where the first code is visible.
  task automatic do_start(input int sb, input int cnt, input logic dir);
    start     = 1'b1;
    start_bin = W'(sb);
    count     = (W+1)'(cnt);
    up_dn     = dir;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records ncyc negedge samples; ready drops for stall_len cycles after stall_after transfers.
  task automatic collect(input int ncyc, input int stall_after, input int stall_len);
    int xfers;
    int stalled;
    xfers = 0;
    stalled = 0;
    q_codes.delete();
    ndone = 0;
    done_cyc = -1;
    last_xfer = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (xfers == stall_after && stalled < stall_len) begin
        gray_ready = 1'b0;
        stalled++;
      end else begin
        gray_ready = 1'b1;
      end
      tr_v[c] = gray_valid;
      tr_r[c] = gray_ready;
      tr_g[c] = gray_out;
      if (gray_valid && gray_ready) begin
        q_codes.push_back(gray_out);
        last_xfer = c;
        xfers++;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    gray_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    start_bin = '0;
    count = '0;
    up_dn = 1'b0;
    gray_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (gray_out !== 4'b0000 || gray_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got gray=%b valid=%b busy=%b done=%b, want 0000 0 0 0",
               gray_out, gray_valid, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_up_seq;
    logic [W-1:0] exp_g[5];
    exp_g = '{4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    do_start(12, 5, 1'b1);
    collect(10, -1, 0);
    n_checks++;
    if (q_codes.size() != 5) begin
      n_fail++;
      $display("FAIL up_count: got %0d codes, want 5", q_codes.size());
    end
    for (int i = 0; i < 5 && i < q_codes.size(); i++) begin
      n_checks++;
      if (q_codes[i] !== exp_g[i]) begin
        n_fail++;
        $display("FAIL up_code[%0d]: got %b, want %b", i, q_codes[i], exp_g[i]);
      end
    end
    n_checks++;
    if (last_xfer != 4) begin
      n_fail++;
      $display("FAIL up_back_to_back: last transfer at cycle %0d, want 4", last_xfer);
    end
    n_checks++;
    if (ndone != 1 || done_cyc != last_xfer + 1) begin
      n_fail++;
      $display("FAIL up_done: got %0d pulses at cycle %0d, want 1 at %0d", ndone, done_cyc, last_xfer + 1);
    end
    n_checks++;
    if (gray_valid !== 1'b0 || busy !== 1'b0 || gray_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL up_after: got valid=%b busy=%b gray=%b, want 0 0 0000", gray_valid, busy, gray_out);
    end
  endtask

  task automatic test_down_wrap;
    logic [W-1:0] exp_g[3];
    logic [W-1:0] exp_b[3];
    exp_g = '{4'b0000, 4'b1000, 4'b1001};
    exp_b = '{4'd0, 4'd15, 4'd14};
    do_start(0, 3, 1'b0);
    collect(8, -1, 0);
    n_checks++;
    if (q_codes.size() != 3) begin
      n_fail++;
      $display("FAIL down_count: got %0d codes, want 3", q_codes.size());
    end
    for (int i = 0; i < 3 && i < q_codes.size(); i++) begin
      n_checks++;
      if (q_codes[i] !== exp_g[i] || g2b(q_codes[i]) !== exp_b[i]) begin
        n_fail++;
        $display("FAIL down_code[%0d]: got %b (bin %0d), want %b (bin %0d)",
                 i, q_codes[i], g2b(q_codes[i]), exp_g[i], exp_b[i]);
      end
    end
    n_checks++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL down_done: got %0d pulses, want 1", ndone);
    end
  endtask

  task automatic test_stall;
    int first_stall;
    do_start(3, 6, 1'b1);
    collect(14, 2, 3);
    n_checks++;
    if (q_codes.size() != 6) begin
      n_fail++;
      $display("FAIL stall_count: got %0d codes, want 6", q_codes.size());
    end
    for (int i = 0; i < 6 && i < q_codes.size(); i++) begin
      n_checks++;
      if (g2b(q_codes[i]) !== W'(3 + i)) begin
        n_fail++;
        $display("FAIL stall_seq[%0d]: got bin %0d, want %0d", i, g2b(q_codes[i]), 3 + i);
      end
    end
    first_stall = -1;
    for (int c = 0; c < 14; c++) begin
      if (!tr_r[c]) begin
        if (first_stall < 0) first_stall = c;
        n_checks++;
        if (tr_v[c] !== 1'b1 || tr_g[c] !== to_gray(5)) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got valid=%b gray=%b, want 1 %b", c, tr_v[c], tr_g[c], to_gray(5));
        end
      end
    end
    n_checks++;
    if (first_stall != 2 || last_xfer != 8 || ndone != 1) begin
      n_fail++;
      $display("FAIL stall_timing: got stall@%0d last@%0d done=%0d, want 2 8 1", first_stall, last_xfer, ndone);
    end
  endtask

  task automatic test_count_zero;
    do_start(7, 0, 1'b1);
    collect(4, -1, 0);
    n_checks++;
    if (q_codes.size() != 0 || ndone != 1 || done_cyc != 0) begin
      n_fail++;
      $display("FAIL count_zero: got %0d codes, %0d done at cycle %0d, want 0 codes, 1 done at 0",
               q_codes.size(), ndone, done_cyc);
    end
  endtask

  task automatic test_full_count;
    int seen[16];
    int bad_seq;
    int bad_ham;
    int dups;
    logic [W-1:0] d;
    do_start(5, 16, 1'b1);
    collect(20, -1, 0);
    n_checks++;
    if (q_codes.size() != 16) begin
      n_fail++;
      $display("FAIL full_count: got %0d codes, want 16", q_codes.size());
    end
    for (int i = 0; i < 16; i++) seen[i] = 0;
    bad_seq = 0;
    bad_ham = 0;
    for (int i = 0; i < q_codes.size(); i++) begin
      seen[int'(q_codes[i])]++;
      if (g2b(q_codes[i]) !== W'(5 + i)) bad_seq++;
      if (i > 0) begin
        d = q_codes[i] ^ q_codes[i-1];
        if ($countones(d) != 1) bad_ham++;
      end
    end
    dups = 0;
    for (int i = 0; i < 16; i++) if (seen[i] != 1) dups++;
    n_checks++;
    if (bad_seq != 0 || bad_ham != 0 || dups != 0) begin
      n_fail++;
      $display("FAIL full_codes: got %0d seq errors, %0d hamming errors, %0d non-unique, want 0 0 0",
               bad_seq, bad_ham, dups);
    end
    n_checks++;
    if (ndone != 1 || done_cyc != 16) begin
      n_fail++;
      $display("FAIL full_done: got %0d pulses at cycle %0d, want 1 at 16", ndone, done_cyc);
    end
  endtask

  task automatic test_reset_abort;
    int nd;
    do_start(0, 10, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (gray_out !== 4'b0000 || gray_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got gray=%b valid=%b busy=%b done=%b, want 0000 0 0 0",
               gray_out, gray_valid, busy, done);
    end
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      if (done || gray_valid) nd++;
      @(negedge clk);
    end
    n_checks++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d cycles with done/valid, want 0", nd);
    end
  endtask

  task automatic test_start_ignored;
    logic [W-1:0] q[$];
    int nd;
    do_start(2, 3, 1'b1);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) begin
        start = 1'b1;
        start_bin = 4'd9;
        count = 5'd8;
        up_dn = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (gray_valid && gray_ready) q.push_back(gray_out);
      if (done) nd++;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (q.size() != 3 || nd != 1) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d codes %0d done, want 3 codes 1 done", q.size(), nd);
    end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      n_checks++;
      if (g2b(q[i]) !== W'(2 + i)) begin
        n_fail++;
        $display("FAIL busy_start_seq[%0d]: got bin %0d, want %0d", i, g2b(q[i]), 2 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_seq();
    test_down_wrap();
    test_stall();
    test_count_zero();
    test_full_count();
    test_reset_abort();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
